bcd_serial_counter_ctrl: RTL and testbench
==========================================

// Module: bcd_serial_counter_ctrl
// PURPOSE
//  Multi-digit BCD up-counter controller that time-shares ONE external single-digit
//  BCD incrementor across NDIG digits, walking LS->MS one digit per clock until the
//  carry dies. Holds the count, queues one pending request, flags overflow/misses.
//  Sits between event sources (buttons, timers) and display/readout logic.
// PARAMETERS
//  NDIG   4   number of BCD digits held (>=2); count width 4*NDIG
//  IDXW   2   digit index width, >= clog2(NDIG)
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  clr        in   1        synchronous clear of count/flags, overrides inc_req
//  inc_req    in   1        increment request, sampled every clk edge
//  busy       out  1        controller not IDLE (WALK or DONE)
//  done       out  1        1-cycle pulse: increment complete, count updated
//  ovf        out  1        valid with done: count wrapped 99..9 -> 00..0
//  miss       out  1        sticky: a request was dropped (pending slot full)
//  bcd_count  out  4*NDIG   current count, digit 0 in [3:0]
//  dig_out    out  4        digit presented to shared incrementor (count[idx])
//  dig_inc    out  1        incrementor enable; 1 only in WALK
//  dig_res    in   4        incrementor result (combinational, same cycle)
//  dig_carry  in   1        incrementor carry (combinational, same cycle)
// BEHAVIOUR
//  Reset (async): state=IDLE, idx=0, bcd_count=0, pend=0; all outputs 0.
//  States: IDLE, WALK, DONE. busy=(state!=IDLE); done=(state==DONE); Moore outputs.
//  IDLE: if pend|inc_req -> WALK, idx=0. pend consumed first; an inc_req in the
//    same cycle is captured into pend (pend stays 1).
//  WALK: dig_out=count[idx], dig_inc=1; count[idx]<=dig_res at edge.
//    dig_carry=0 -> DONE, ovf_r=0.
//    dig_carry=1, idx<NDIG-1 -> idx+1, stay WALK.
//    dig_carry=1, idx==NDIG-1 -> DONE, ovf_r=1 (all digits now 0).
//  DONE: one cycle; -> IDLE. ovf=ovf_r & done.
//  Outside WALK: dig_inc=0, dig_out=count[idx] (don't-care to incrementor).
//  Latency: request sampled at edge E0; k digits touched -> WALK k cycles,
//    done high in cycle k+1 after E0; busy for k+1 cycles. Min 2 (k=1), max NDIG+1.
//  inc_req while busy: pend=0 -> pend=1; pend=1 -> dropped, miss<=1 (sticky).
//  Back-to-back: queued request starts from IDLE, so DONE->IDLE->WALK (1 idle cycle).
//  clr: next edge count=0, idx=0, pend=0, miss=0, state=IDLE; aborts WALK (partial
//    update discarded by zeroing); inc_req in clr cycle ignored; done not pulsed.
//  Reset mid-WALK: immediate return to reset values, no done.
//  Count digits only ever written from dig_res/zero; incrementor guarantees BCD.
//  inc_req is level-sampled: held high for N cycles = repeated requests (source
//    must pulse one cycle per event).
// TESTING
//  T1 count=0000, 1-cycle inc_req -> busy 2 cycles, done 2nd cycle, count=0001, ovf=0.
//  T2 count=0099, inc_req -> 3 WALK cycles dig_out 9,9,0; done; count=0100.
//  T3 count=9999, inc_req -> 4 WALK cycles, done with ovf=1, count=0000.
//  T4 count=0009: req, req 1 cycle later, req 2 cycles later -> 2nd pended, 3rd sets
//     miss=1; final count=0011, two done pulses, miss stays 1 until clr.
//  T5 count=0999, req, clr during 2nd WALK cycle -> next cycle IDLE, count=0000,
//     no done, miss=0, dig_inc=0.
//  T6 reset asserted mid-WALK asynchronously -> outputs 0 before next clk edge;
//     after release, req -> count=0001.

Source files
------------

// File: rtl/bcd_serial_counter_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_counter_ctrl
//
// Multi-digit BCD up-counter that shares one external single-digit BCD
// incrementor across NDIG digits. An increment walks the digits from least
// to most significant, one digit per clock, and stops as soon as the carry
// dies. One further request can wait in a single pending slot. A request that
// arrives while that slot is already full is dropped and raises a sticky miss
// flag.
//
// Parameters
//   NDIG  number of BCD digits held (>= 2); the count is 4*NDIG bits wide
//   IDXW  digit index width, >= clog2(NDIG)
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-high reset
//   clr        in   synchronous clear of count, flags and pending request;
//                   takes priority over inc_req
//   inc_req    in   increment request, level-sampled on every clock edge
//   busy       out  controller is walking digits or signalling completion
//   done       out  one-cycle pulse: the increment is complete and the count
//                   has been updated
//   ovf        out  valid together with done: the count wrapped from all
//                   nines to zero
//   miss       out  sticky: a request was dropped because the pending slot
//                   was full
//   bcd_count  out  current count; digit 0 is in [3:0]
//   dig_out    out  digit presented to the shared incrementor
//   dig_inc    out  incrementor enable; high only while walking
//   dig_res    in   incrementor result (combinational, same cycle)
//   dig_carry  in   incrementor carry (combinational, same cycle)
// ---------------------------------------------------------------------------
module bcd_serial_counter_ctrl #(
  parameter int NDIG = 4,
  parameter int IDXW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc_req,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              miss,
  output logic [4*NDIG-1:0] bcd_count,
  output logic [3:0]        dig_out,
  output logic              dig_inc,
  input  logic [3:0]        dig_res,
  input  logic              dig_carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q,   idx_d;
  logic [4*NDIG-1:0] count_q, count_d;
  logic              pend_q,  pend_d;
  logic              miss_q,  miss_d;
  logic              ovf_q,   ovf_d;

  // Digit currently addressed by the walk index.
  logic [3:0] cur_digit;
  assign cur_digit = count_q[{idx_q, 2'b00} +: 4];

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      miss_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      miss_q  <= miss_d;
      ovf_q   <= ovf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pend_q || inc_req) state_d = WALK;
      WALK: if (!dig_carry || (idx_q == LAST_IDX)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // -------------------------------------------------------------------------
  // Datapath next-value logic: walk index, count digits, pending slot,
  // miss and overflow flags
  // -------------------------------------------------------------------------
  always_comb begin
    idx_d   = idx_q;
    count_d = count_q;
    pend_d  = pend_q;
    miss_d  = miss_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (pend_q || inc_req) begin
          idx_d = '0;
          // The pending request is served first. An inc_req arriving in the
          // same cycle takes its place in the slot. Without a pending request,
          // inc_req starts the walk directly and the slot stays empty.
          pend_d = pend_q ? inc_req : 1'b0;
        end
      end
      WALK: begin
        count_d[{idx_q, 2'b00} +: 4] = dig_res;
        if (!dig_carry) begin
          ovf_d = 1'b0;
        end else if (idx_q != LAST_IDX) begin
          idx_d = idx_q + IDXW'(1);
        end else begin
          // The carry ran out of the top digit, so every digit is now zero.
          ovf_d = 1'b1;
        end
      end
      default: ;
    endcase

    // While busy, a new request fills the empty slot or is dropped.
    if ((state_q != IDLE) && inc_req) begin
      if (!pend_q) pend_d = 1'b1;
      else         miss_d = 1'b1;
    end

    // Clear zeroes the count, which discards a partially walked update.
    if (clr) begin
      idx_d   = '0;
      count_d = '0;
      pend_d  = 1'b0;
      miss_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Moore outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    dig_inc   = (state_q == WALK);
    ovf       = ovf_q && (state_q == DONE);
    miss      = miss_q;
    bcd_count = count_q;
    dig_out   = cur_digit;
  end

endmodule

// File: tb/tb_bcd_serial_counter_ctrl.sv
module tb_bcd_serial_counter_ctrl;

  localparam int NDIG = 4;
  localparam int MOD  = 10 ** NDIG;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clr = 1'b0;
  logic              inc_req = 1'b0;
  logic              busy, done, ovf, miss, dig_inc, dig_carry;
  logic [4*NDIG-1:0] bcd_count;
  logic [3:0]        dig_out, dig_res;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // External shared single-digit BCD incrementor.
  assign dig_carry = (dig_out == 4'd9);
  assign dig_res   = (dig_out >= 4'd9) ? 4'd0 : dig_out + 4'd1;

  bcd_serial_counter_ctrl #(.NDIG(4), .IDXW(2)) dut (
    .clk(clk), .reset(reset), .clr(clr), .inc_req(inc_req),
    .busy(busy), .done(done), .ovf(ovf), .miss(miss),
    .bcd_count(bcd_count), .dig_out(dig_out), .dig_inc(dig_inc),
    .dig_res(dig_res), .dig_carry(dig_carry)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int j);
    int r = 1;
    for (int i = 0; i < j; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*NDIG-1:0] to_bcd(input int v);
    logic [4*NDIG-1:0] r = '0;
    for (int j = 0; j < NDIG; j++) r[4*j +: 4] = 4'((v / pow10(j)) % 10);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model. The count is an integer. An operation that starts from
  // value old needs k cycles of walking, where k is one more than the number
  // of trailing nines, capped at NDIG. After j walk cycles, the low j decimal
  // digits hold the new value and the upper digits still hold the old value.
  // m_step is 0 when idle, 1..k during the walk, and k+1 during completion.
  // ---------------------------------------------------------------------------
  int m_count = 0, m_old = 0, m_k = 1, m_step = 0;
  bit m_pend = 0, m_miss = 0;

  always @(posedge clk or posedge reset) begin
    int c, o, k, s, v, p;
    bit pd, ms;
    if (reset) begin
      m_count <= 0; m_old <= 0; m_k <= 1; m_step <= 0; m_pend <= 0; m_miss <= 0;
    end else begin
      c = m_count; o = m_old; k = m_k; s = m_step; pd = m_pend; ms = m_miss;
      if (clr) begin
        c = 0; s = 0; pd = 0; ms = 0;
      end else if (m_step == 0) begin
        if (m_pend || inc_req) begin
          o = m_count;
          k = 1; v = m_count;
          while ((v % 10 == 9) && (k < NDIG)) begin v = v / 10; k++; end
          s = 1;
          pd = m_pend ? inc_req : 1'b0;
        end
      end else begin
        if (m_step <= m_k) begin
          p = pow10(m_step);
          c = (((m_old + 1) % MOD) % p) + m_old - (m_old % p);
          s = m_step + 1;
        end else begin
          s = 0;
        end
        if (inc_req) begin
          if (!m_pend) pd = 1; else ms = 1;
        end
      end
      m_count <= c; m_old <= o; m_k <= k; m_step <= s; m_pend <= pd; m_miss <= ms;
    end
  end

  // Compare process: checks the DUT against the model on every falling edge.
  always @(negedge clk) begin
    bit e_walk, e_done;
    e_walk = (m_step >= 1) && (m_step <= m_k);
    e_done = (m_step != 0) && (m_step == m_k + 1);
    chk("m_busy", 32'(busy), 32'(m_step != 0));
    chk("m_done", 32'(done), 32'(e_done));
    chk("m_ovf", 32'(ovf), 32'(e_done && (m_old == MOD - 1)));
    chk("m_dig_inc", 32'(dig_inc), 32'(e_walk));
    chk("m_miss", 32'(miss), 32'(m_miss));
    chk("m_count", 32'(bcd_count), 32'(to_bcd(m_count)));
    if (e_walk) chk("m_dig_out", 32'(dig_out), 32'((m_old / pow10(m_step - 1)) % 10));
  end

  // One-cycle request pulse, then wait (bounded) for the controller to go idle.
  task automatic pump(input int n);
    for (int i = 0; i < n; i++) begin
      bit idle = 0;
      @(posedge clk); #2 inc_req = 1'b1;
      @(posedge clk); #2 inc_req = 1'b0;
      for (int t = 0; t < 20 && !idle; t++) begin
        @(negedge clk);
        if (!busy) idle = 1;
      end
      if (!idle) chk("pump_timeout", 32'(busy), 32'd0);
    end
  endtask

  // One request with hand-computed expectations for the timeline, the digits
  // presented to the incrementor, the overflow flag and the final count.
  task automatic req_watch(input string nm, input int k, input logic exp_ovf,
                           input logic [15:0] exp_digs, input logic [15:0] exp_cnt);
    @(posedge clk); #2 inc_req = 1'b1;
    @(posedge clk); #2 inc_req = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk({nm, "_walk_busy"}, 32'(busy), 32'd1);
      chk({nm, "_walk_done"}, 32'(done), 32'd0);
      chk({nm, "_walk_inc"}, 32'(dig_inc), 32'd1);
      chk({nm, "_dig_out"}, 32'(dig_out), 32'(exp_digs[4*i +: 4]));
    end
    @(negedge clk);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({nm, "_done_inc"}, 32'(dig_inc), 32'd0);
    @(negedge clk);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    chk({nm, "_count"}, 32'(bcd_count), 32'(exp_cnt));
  endtask

  initial begin
    int ndone;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(bcd_count), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    #3 reset = 1'b0;

    // T1
    req_watch("t1", 1, 1'b0, 16'h0000, 16'h0001);
    // T2
    pump(98);
    chk("t2_pre", 32'(bcd_count), 32'h0099);
    req_watch("t2", 3, 1'b0, 16'h0099, 16'h0100);
    // T3
    pump(9899);
    chk("t3_pre", 32'(bcd_count), 32'h9999);
    req_watch("t3", 4, 1'b1, 16'h9999, 16'h0000);

    // T4: requests on three consecutive edges, starting from 0009.
    pump(9);
    chk("t4_pre", 32'(bcd_count), 32'h0009);
    @(posedge clk); #2 inc_req = 1'b1;
    repeat (3) @(posedge clk);
    #2 inc_req = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t4_done_pulses", 32'(ndone), 32'd2);
    chk("t4_count", 32'(bcd_count), 32'h0011);
    chk("t4_miss", 32'(miss), 32'd1);
    pump(988);
    chk("t4_miss_sticky", 32'(miss), 32'd1);
    chk("t5_pre", 32'(bcd_count), 32'h0999);

    // T5: clear during the second walk cycle.
    @(posedge clk); #2 inc_req = 1'b1;
    @(posedge clk); #2 inc_req = 1'b0;
    @(posedge clk); #2 clr = 1'b1;
    @(posedge clk); #2 clr = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_count", 32'(bcd_count), 32'd0);
    chk("t5_miss", 32'(miss), 32'd0);
    chk("t5_inc", 32'(dig_inc), 32'd0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);

    // T6: asynchronous reset in the middle of a walk.
    pump(99);
    @(posedge clk); #2 inc_req = 1'b1;
    @(posedge clk); #2 inc_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_inc", 32'(dig_inc), 32'd0);
    chk("t6_count", 32'(bcd_count), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    @(negedge clk); #3 reset = 1'b0;
    req_watch("t6", 1, 1'b0, 16'h0000, 16'h0001);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
